// File: rtl/alux_param.sv
// alux_param: complex-number ALU with a start/busy/done handshake.
// Operands and result are packed {Re, Im}, each component DW-bit two's complement
// with FRAC fractional bits. Multiplies take MUL_LAT cycles; the other ops take one.
// Ports:
//   clock, reset     master clock (posedge), asynchronous active-low reset
//   start            request, accepted only while busy=0
//   opr, inA, inB    opcode and operands, captured when start is accepted
//   outAB            registered result, held until the next done
//   done             one-cycle pulse marking outAB/ovf/err valid
//   busy             op in flight
//   ovf, err         overflow in either component / unsupported opcode
module alux_param #(
  parameter int unsigned DW      = 32,
  parameter int unsigned FRAC    = 0,
  parameter bit          SAT     = 1'b1,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    opr,
  input  logic [2*DW-1:0] inA,
  input  logic [2*DW-1:0] inB,
  output logic [2*DW-1:0] outAB,
  output logic          done,
  output logic          busy,
  output logic          ovf,
  output logic          err
);

  // Wide enough for a sum/difference of two 2DW-bit products without loss.
  localparam int unsigned WW = 2 * DW + 2;
  localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      opr_q;
  logic [2*DW-1:0] a_q;
  logic [2*DW-1:0] b_q;

  function automatic logic signed [WW-1:0] sext(input logic signed [DW-1:0] x);
    return {{(WW - DW){x[DW-1]}}, x};
  endfunction

  function automatic logic signed [2*DW-1:0] ext2(input logic signed [DW-1:0] x);
    return {{DW{x[DW-1]}}, x};
  endfunction

  function automatic logic signed [WW-1:0] sextp(input logic signed [2*DW-1:0] p);
    return {{2{p[2*DW-1]}}, p};
  endfunction

  // Narrow a wide signed value to DW bits; returns {overflow, value}.
  function automatic logic [DW:0] narrow(input logic signed [WW-1:0] v);
    logic signed [WW-1:0] max_v;
    logic signed [WW-1:0] min_v;
    logic [DW-1:0]        r;
    logic                 o;
    max_v = {{(WW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    min_v = {{(WW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};
    o     = 1'b0;
    r     = v[DW-1:0];
    if (v > max_v) begin
      o = 1'b1;
      if (SAT) r = {1'b0, {(DW - 1){1'b1}}};
    end else if (v < min_v) begin
      o = 1'b1;
      if (SAT) r = {1'b1, {(DW - 1){1'b0}}};
    end
    return {o, r};
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == 4'h4) || (op == 4'h5) || (op == 4'h6);
  endfunction

  logic signed [DW-1:0]   ar, ai, br, bi;
  logic signed [2*DW-1:0] p_rr, p_ii, p_ri, p_ir;

  assign ar = a_q[2*DW-1:DW];
  assign ai = a_q[DW-1:0];
  assign br = b_q[2*DW-1:DW];
  assign bi = b_q[DW-1:0];

  // Exact 2DW-bit products; operands are pre-extended so no bits are lost.
  assign p_rr = ext2(ar) * ext2(br);
  assign p_ii = ext2(ai) * ext2(bi);
  assign p_ri = ext2(ar) * ext2(bi);
  assign p_ir = ext2(ai) * ext2(br);

  logic [2*DW-1:0] res_d;
  logic            ovf_d;
  logic            err_d;
  logic [DW:0]     nr, ni;
  logic            use_n;

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    err_d = 1'b0;
    nr    = '0;
    ni    = '0;
    use_n = 1'b0;
    case (opr_q)
      4'h0: res_d = a_q;
      4'h1: res_d = b_q;
      4'h2: begin
        nr    = narrow(sext(ar) + sext(br));
        ni    = narrow(sext(ai) + sext(bi));
        use_n = 1'b1;
      end
      4'h3: begin
        nr    = narrow(sext(ar) - sext(br));
        ni    = narrow(sext(ai) - sext(bi));
        use_n = 1'b1;
      end
      4'h4: begin
        nr    = narrow((sextp(p_rr) - sextp(p_ii)) >>> FRAC);
        ni    = narrow((sextp(p_ri) + sextp(p_ir)) >>> FRAC);
        use_n = 1'b1;
      end
      4'h5: begin
        nr    = narrow((sextp(p_rr) + sextp(p_ii)) >>> FRAC);
        ni    = narrow((sextp(p_ri) - sextp(p_ir)) >>> FRAC);
        use_n = 1'b1;
      end
      4'h6: begin
        nr    = narrow(sextp(p_rr) >>> FRAC);
        ni    = narrow(sextp(p_ii) >>> FRAC);
        use_n = 1'b1;
      end
      4'h7: begin
        nr    = narrow(sext(ar));
        ni    = narrow(-sext(ai));
        use_n = 1'b1;
      end
      4'h8: res_d = {{(2 * DW - 1){1'b0}}, (a_q == b_q)};
      4'h9: begin
        nr    = narrow(-sext(ar));
        ni    = narrow(-sext(ai));
        use_n = 1'b1;
      end
      4'hA: res_d = {a_q[DW-1:0], a_q[2*DW-1:DW]};
      default: err_d = 1'b1;
    endcase
    if (use_n) begin
      res_d = {nr[DW-1:0], ni[DW-1:0]};
      ovf_d = nr[DW] | ni[DW];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      outAB   <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        // DONE accepts a new start exactly like IDLE for back-to-back throughput.
        StIdle, StDone: begin
          if (start) begin
            opr_q   <= opr;
            a_q     <= inA;
            b_q     <= inB;
            cnt_q   <= is_mul(opr) ? CW'(MUL_LAT - 1) : '0;
            busy    <= 1'b1;
            state_q <= StExec;
          end else begin
            state_q <= StIdle;
          end
        end
        StExec: begin
          if (cnt_q == '0) begin
            outAB   <= res_d;
            ovf     <= ovf_d;
            err     <= err_d;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alux_param.sv
module tb_alux_param;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  opr;
  logic [63:0] inA, inB;
  logic        start_v [2];
  logic [63:0] out_v   [2];
  logic        done_v  [2];
  logic        busy_v  [2];
  logic        ovf_v   [2];
  logic        err_v   [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  alux_param #(.DW(32), .FRAC(0), .SAT(1'b1), .MUL_LAT(3)) u_dut0 (
    .clock(clock), .reset(reset), .start(start_v[0]), .opr(opr), .inA(inA), .inB(inB),
    .outAB(out_v[0]), .done(done_v[0]), .busy(busy_v[0]), .ovf(ovf_v[0]), .err(err_v[0])
  );

  alux_param #(.DW(32), .FRAC(4), .SAT(1'b0), .MUL_LAT(2)) u_dut1 (
    .clock(clock), .reset(reset), .start(start_v[1]), .opr(opr), .inA(inA), .inB(inB),
    .outAB(out_v[1]), .done(done_v[1]), .busy(busy_v[1]), .ovf(ovf_v[1]), .err(err_v[1])
  );

  function automatic bit sat_of(input int inst);  return inst == 0; endfunction
  function automatic int frac_of(input int inst); return (inst == 0) ? 0 : 4; endfunction
  function automatic int lat_of(input int inst, input logic [3:0] op);
    if (op == 4'h4 || op == 4'h5 || op == 4'h6) return (inst == 0) ? 3 : 2;
    return 1;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Clip an exact integer into 32-bit two's complement; returns {ovf, value}.
  function automatic logic [32:0] clip(input logic signed [127:0] v, input bit sat);
    logic signed [127:0] mx, mn;
    mx = 128'sh7fffffff;
    mn = -128'sh80000000;
    if (v > mx) return {1'b1, sat ? 32'h7fffffff : v[31:0]};
    if (v < mn) return {1'b1, sat ? 32'h80000000 : v[31:0]};
    return {1'b0, v[31:0]};
  endfunction

  task automatic ref_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input bit sat, input int frac,
                        output logic [63:0] r, output bit o, output bit e);
    logic signed [127:0] ar, ai, br, bi, vr, vi;
    logic [32:0] cr, ci;
    bit cplx;
    ar = $signed(a[63:32]); ai = $signed(a[31:0]);
    br = $signed(b[63:32]); bi = $signed(b[31:0]);
    vr = 0; vi = 0; r = 0; o = 0; e = 0; cplx = 1;
    case (op)
      4'h0: begin r = a; cplx = 0; end
      4'h1: begin r = b; cplx = 0; end
      4'h2: begin vr = ar + br; vi = ai + bi; end
      4'h3: begin vr = ar - br; vi = ai - bi; end
      4'h4: begin vr = (ar * br - ai * bi) >>> frac; vi = (ar * bi + ai * br) >>> frac; end
      4'h5: begin vr = (ar * br + ai * bi) >>> frac; vi = (ar * bi - ai * br) >>> frac; end
      4'h6: begin vr = (ar * br) >>> frac; vi = (ai * bi) >>> frac; end
      4'h7: begin vr = ar; vi = -ai; end
      4'h8: begin r = (a == b) ? 64'd1 : 64'd0; cplx = 0; end
      4'h9: begin vr = -ar; vi = -ai; end
      4'hA: begin r = {a[31:0], a[63:32]}; cplx = 0; end
      default: begin e = 1; cplx = 0; end
    endcase
    if (cplx) begin
      cr = clip(vr, sat);
      ci = clip(vi, sat);
      r  = {cr[31:0], ci[31:0]};
      o  = cr[32] | ci[32];
    end
  endtask

  function automatic logic [31:0] rnd_comp();
    case ($urandom_range(0, 5))
      0: return 32'h7fffffff;
      1: return 32'h80000000;
      2: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op on the chosen instance, scramble inputs after capture, check timing and result.
  task automatic do_op(input int inst, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] got);
    logic [63:0] r;
    bit o, e, seen;
    int n, lat;
    ref_op(op, a, b, sat_of(inst), frac_of(inst), r, o, e);
    lat = lat_of(inst, op);
    @(negedge clock);
    opr = op; inA = a; inB = b; start_v[inst] = 1'b1;
    @(posedge clock); #1;
    check_eq("busy_after_start", 64'(busy_v[inst]), 64'd1);
    @(negedge clock);
    start_v[inst] = 1'b0;
    inA = {$urandom, $urandom}; inB = {$urandom, $urandom}; opr = 4'($urandom);
    seen = 0;
    n = 1;
    while (n <= lat + 3 && !seen) begin
      @(posedge clock); #1;
      if (done_v[inst]) seen = 1;
      else n++;
    end
    check_eq("latency", 64'(n), 64'(lat));
    check_eq("outAB", out_v[inst], r);
    check_eq("ovf", 64'(ovf_v[inst]), 64'(o));
    check_eq("err", 64'(err_v[inst]), 64'(e));
    check_eq("busy_at_done", 64'(busy_v[inst]), 64'd0);
    got = out_v[inst];
  endtask

  task automatic check_idle_zero(input string tag, input int inst);
    check_eq({tag, "_out"},  out_v[inst], 64'd0);
    check_eq({tag, "_done"}, 64'(done_v[inst]), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy_v[inst]), 64'd0);
    check_eq({tag, "_ovf"},  64'(ovf_v[inst]), 64'd0);
    check_eq({tag, "_err"},  64'(err_v[inst]), 64'd0);
  endtask

  initial begin
    logic [63:0] got, r;
    logic [63:0] ta [10];
    logic [63:0] tb [10];
    bit o, e;
    int ndone;

    reset = 1'b0; start_v[0] = 1'b0; start_v[1] = 1'b0;
    opr = '0; inA = '0; inB = '0;
    repeat (2) @(negedge clock);
    check_idle_zero("reset0", 0);
    check_idle_zero("reset1", 1);
    reset = 1'b1;

    // Directed cases.
    do_op(0, 4'h2, {32'd3, 32'd4}, {32'd1, -32'sd2}, got);
    check_eq("t1_add", got, {32'd4, 32'd2});
    do_op(0, 4'h4, {32'd3, 32'd4}, {32'd1, -32'sd2}, got);
    check_eq("t2_mul", got, {32'd11, -32'sd2});
    do_op(0, 4'h2, {32'h7fffffff, 32'd0}, {32'd1, 32'd0}, got);
    check_eq("t3_sat", got, {32'h7fffffff, 32'd0});
    check_eq("t3_sat_ovf", 64'(ovf_v[0]), 64'd1);
    do_op(1, 4'h2, {32'h7fffffff, 32'd0}, {32'd1, 32'd0}, got);
    check_eq("t3_wrap", got, {32'h80000000, 32'd0});
    check_eq("t3_wrap_ovf", 64'(ovf_v[1]), 64'd1);
    do_op(0, 4'hF, 64'h1234, 64'h5678, got);
    check_eq("t6_err_out", got, 64'd0);
    check_eq("t6_err", 64'(err_v[0]), 64'd1);
    do_op(0, 4'h8, 64'hdead_beef_0123_4567, 64'hdead_beef_0123_4567, got);
    check_eq("t6_eq", got, 64'd1);
    do_op(0, 4'h9, {32'h80000000, 32'd5}, 64'd0, got);
    check_eq("neg_min_sat", got, {32'h7fffffff, -32'sd5});
    do_op(1, 4'h9, {32'h80000000, 32'd5}, 64'd0, got);
    check_eq("neg_min_wrap", got, {32'h80000000, -32'sd5});

    // Sustained start: accepted on even edges, done after odd edges.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      ta[i] = {rnd_comp(), rnd_comp()};
      tb[i] = {rnd_comp(), rnd_comp()};
      opr = 4'h3; inA = ta[i]; inB = tb[i]; start_v[0] = 1'b1;
      @(posedge clock); #1;
      if (i % 2 == 1) begin
        ref_op(4'h3, ta[i-1], tb[i-1], 1'b1, 0, r, o, e);
        check_eq("stream_done", 64'(done_v[0]), 64'd1);
        check_eq("stream_out", out_v[0], r);
      end else begin
        check_eq("stream_gap", 64'(done_v[0]), 64'd0);
      end
    end
    @(negedge clock);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clock);

    // Reset mid-multiply drops the op.
    do_op(0, 4'h0, 64'hffff_0000_1234_5678, 64'd0, got);
    @(negedge clock);
    opr = 4'h4; inA = {$urandom, $urandom}; inB = {$urandom, $urandom}; start_v[0] = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    start_v[0] = 1'b0;
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check_idle_zero("midop_reset", 0);
    @(negedge clock);
    reset = 1'b1;
    ndone = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (done_v[0]) ndone++;
    end
    check_eq("no_done_after_reset", 64'(ndone), 64'd0);
    do_op(0, 4'h5, {32'd7, -32'sd3}, {32'd2, 32'd9}, got);

    // Randomized ops on both configurations.
    for (int k = 0; k < 160; k++) begin
      do_op(k % 2, 4'($urandom_range(0, 15)), {rnd_comp(), rnd_comp()},
            {rnd_comp(), rnd_comp()}, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
